spi_mpu_seq: RTL and testbench
==============================

Name: spi_mpu_seq

Overview:
- Sequencer that drives one spi_mpu_get engine to burst-read a contiguous block of MPU registers (default 0x3B..0x48: accel, temp, gyro).
- Reads run either on a periodic tick or on a manual trigger.
- Each byte is collected into a working buffer; the whole frame is copied to a coherent output shadow only on completion.
- Sits between the sensor-fusion logic and the SPI read engine, which is the sole owner of the bus.

Parameters:
- NREG, 14, number of consecutive registers per frame (1..16).
- BASE_ADDR, 7'h3B, first register address (7-bit).
- RATE_DIV, 50000, clk cycles between periodic frames (0 = periodic mode disabled).
- TIMEOUT, 1023, max clk cycles to wait for spi_finish before aborting.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  allows periodic frames
- trigger  in  1  single-cycle request for one frame
- clr_err  in  1  clears sticky error flags
- spi_busy  in  1  from read engine
- spi_finish  in  1  one-cycle pulse, read byte valid
- spi_data  in  8  byte returned by engine
- spi_start  out  1  one-cycle start pulse to engine
- spi_addr  out  8  {1'b1 read bit, reg[6:0]}
- frame  out  NREG*8  latest complete frame; byte k at [8k+7:8k] = register BASE_ADDR+k
- frame_valid  out  1  one-cycle pulse when frame updates
- seq_busy  out  1  high from frame start until DONE exits
- overrun  out  1  sticky: request arrived while seq_busy
- timeout_err  out  1  sticky: engine failed to finish

Behaviour:
- Reset: all outputs 0, frame = 0, state IDLE, rate counter 0, index 0.
- Rate counter:
  - Free-runs 0..RATE_DIV-1 while enable=1 and RATE_DIV!=0; held at 0 otherwise.
  - Wrap produces an internal tick.
- Request = tick | trigger. Simultaneous tick and trigger count as one request.
- Request while seq_busy=1: dropped; overrun set.
- States:
  - IDLE: on request → ISSUE with idx=0 and seq_busy=1.
  - ISSUE: spi_start=1 for exactly one cycle with spi_addr={1'b1, BASE_ADDR+idx}; → WAIT and clear the wait counter. spi_addr holds stable through WAIT.
  - If spi_busy=1 on entry to ISSUE, stay in ISSUE with spi_start=0 until spi_busy=0. This is the only case where ISSUE lasts more than one cycle.
  - WAIT: on spi_finish, store spi_data into buf[idx]. If idx==NREG-1 → DONE, else idx+1 → ISSUE.
  - WAIT timeout: if the wait counter reaches TIMEOUT without spi_finish, set timeout_err and go → IDLE. The frame output is left unchanged and frame_valid is not pulsed.
  - DONE: frame ← buf, frame_valid=1 for one cycle, seq_busy=0 → IDLE.
- Latency: first spi_start occurs 2 cycles after the request edge (request registered in IDLE, pulse in ISSUE).
- Per byte: ISSUE (1) + engine time + 1 cycle. Frame output updates 1 cycle after the last finish.
- BASE_ADDR+idx wraps modulo 128; the read bit is always 1.
- clr_err clears both sticky flags. If clr_err and a new error occur in the same cycle, the flag stays set (set wins).
- spi_finish outside WAIT is ignored.
- Asynchronous rst mid-frame returns to the reset state immediately; buf and frame are cleared.

Decomposition:
- Package spi_mpu_pkg holds:
  - state encoding (IDLE, ISSUE, WAIT, DONE)
  - MPU_READ_BIT constant
  - MPU_ACCEL_XOUT_H = 7'h3B
  - default NREG
- Natural sub-module: spi_mpu_rate_gen (rate counter and tick), reusable by other sampled peripherals.
- The FSM and buffer stay in the top module.

Test Plan:
- Manual trigger, NREG=3, BASE_ADDR=0x3B, engine model returns 0xA1/0xB2/0xC3 → spi_addr sequence 0xBB, 0xBC, 0xBD. frame=0xC3B2A1 and one frame_valid pulse. spi_start appears 2 cycles after trigger.
- Periodic mode: RATE_DIV=100, enable=1 for 1000 cycles with a fast engine → exactly 10 frame_valid pulses spaced 100 cycles apart; overrun=0.
- Overrun: trigger again mid-frame → overrun=1. The frame completes normally and no second frame is started. clr_err → overrun=0.
- Timeout: engine never pulses finish, TIMEOUT=20 → timeout_err=1 21 cycles after spi_start. State returns to IDLE; frame is unchanged; no frame_valid.
- Reset mid-frame: assert rst after byte 1 of 3 → all outputs 0 asynchronously. After release, the next trigger reads from idx 0 (spi_addr=0xBB).
- Busy engine at ISSUE: hold spi_busy=1 for 5 cycles → spi_start is withheld, then issued once spi_busy=0.

Source files
------------

// File: rtl/spi_mpu_pkg.sv
// rtl/spi_mpu_pkg.sv - shared types and constants for the MPU burst-read sequencer
// Purpose: sequencer state encoding, MPU register constants and default frame size.
package spi_mpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // MSB of the SPI address byte selects a register read on the MPU
    localparam logic       MPU_READ_BIT     = 1'b1;
    localparam logic [6:0] MPU_ACCEL_XOUT_H = 7'h3B;
    // ACCEL_XOUT_H .. GYRO_ZOUT_L
    localparam int         DEFAULT_NREG     = 14;

endpackage

// File: rtl/spi_mpu_rate_gen.sv
// rtl/spi_mpu_rate_gen.sv - free-running sample-rate divider producing a one-cycle tick
// Purpose: counts 0..RATE_DIV-1 while enabled and pulses tick on the wrap cycle.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous reset, active-high
//   enable in  counter runs while high, held at 0 otherwise
//   tick   out one-cycle pulse on the last count (RATE_DIV = 0 disables it)
module spi_mpu_rate_gen
    import spi_mpu_pkg::*;
#(
    parameter int RATE_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int             CW       = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = (RATE_DIV > 0) ? CW'(RATE_DIV - 1) : '0;
    localparam logic           ACTIVE   = (RATE_DIV != 0);

    logic [CW-1:0] r_cnt;
    logic          w_run;

    assign w_run = ACTIVE && enable;
    assign tick  = w_run && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_run || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_mpu_seq.sv
// rtl/spi_mpu_seq.sv - burst-read sequencer driving one spi_mpu_get engine
// Purpose: reads NREG consecutive MPU registers per frame (periodic tick or trigger),
//          collects bytes in a working buffer and publishes the frame atomically.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   enable           allows periodic frames
//   trigger          single-cycle request for one frame
//   clr_err          clears sticky overrun / timeout_err
//   spi_busy         engine busy
//   spi_finish       engine one-cycle pulse, spi_data valid
//   spi_data         byte returned by engine
//   spi_start        one-cycle start pulse to engine
//   spi_addr         {read bit, register address}
//   frame            last complete frame, byte k = register BASE_ADDR+k
//   frame_valid      one-cycle pulse when frame updates
//   seq_busy         frame in progress
//   overrun          sticky: request dropped because a frame was in progress
//   timeout_err      sticky: engine never finished a byte
module spi_mpu_seq
    import spi_mpu_pkg::*;
#(
    parameter int         NREG      = DEFAULT_NREG,
    parameter logic [6:0] BASE_ADDR = MPU_ACCEL_XOUT_H,
    parameter int         RATE_DIV  = 50000,
    parameter int         TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              trigger,
    input  logic              clr_err,
    input  logic              spi_busy,
    input  logic              spi_finish,
    input  logic [7:0]        spi_data,
    output logic              spi_start,
    output logic [7:0]        spi_addr,
    output logic [NREG*8-1:0] frame,
    output logic              frame_valid,
    output logic              seq_busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    // the counter is compared before its increment, so TIMEOUT-1 means TIMEOUT cycles waited
    localparam logic [TW-1:0] WAIT_END = TW'(TIMEOUT - 1);
    localparam logic [3:0]    LAST_IDX = 4'(NREG - 1);

    seq_state_t        r_state, w_state_next;
    logic              r_req;
    logic [3:0]        r_idx;
    logic [7:0]        r_spi_addr;
    logic [TW-1:0]     r_wait_cnt;
    logic [NREG*8-1:0] r_buf, r_frame, w_buf_next;
    logic              r_overrun, r_timeout_err;
    logic              w_tick, w_req, w_pending, w_byte_done, w_timeout;

    spi_mpu_rate_gen #(.RATE_DIV(RATE_DIV)) u_rate_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (w_tick)
    );

    assign w_req       = w_tick | trigger;
    assign seq_busy    = (r_state != ST_IDLE);
    // a registered request not yet consumed by IDLE also blocks new requests
    assign w_pending   = seq_busy | r_req;
    assign spi_addr    = r_spi_addr;
    assign frame       = r_frame;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

    always_comb begin
        w_buf_next = r_buf;
        for (int k = 0; k < NREG; k++) begin
            if (r_idx == 4'(k)) begin
                w_buf_next[8*k +: 8] = spi_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        spi_start    = 1'b0;
        frame_valid  = 1'b0;
        w_byte_done  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_req) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!spi_busy) begin
                    spi_start    = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (spi_finish) begin
                    w_byte_done  = 1'b1;
                    w_state_next = (r_idx == LAST_IDX) ? ST_DONE : ST_ISSUE;
                end else if (r_wait_cnt == WAIT_END) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                frame_valid  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_req         <= 1'b0;
            r_idx         <= '0;
            r_spi_addr    <= '0;
            r_wait_cnt    <= '0;
            r_buf         <= '0;
            r_frame       <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= w_req && !w_pending;

            case (r_state)
                ST_IDLE: begin
                    if (r_req) begin
                        r_idx      <= '0;
                        r_spi_addr <= {MPU_READ_BIT, BASE_ADDR};
                    end
                end
                ST_ISSUE: r_wait_cnt <= '0;
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + TW'(1);
                    if (w_byte_done) begin
                        r_buf <= w_buf_next;
                        if (r_idx == LAST_IDX) begin
                            // publish straight from the merged buffer so frame and frame_valid align
                            r_frame <= w_buf_next;
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_spi_addr <= {MPU_READ_BIT, BASE_ADDR + 7'(r_idx + 4'd1)};
                        end
                    end
                end
                default: ;
            endcase

            // a new error in the same cycle as clr_err keeps the flag set
            if (w_req && w_pending) r_overrun <= 1'b1;
            else if (clr_err)       r_overrun <= 1'b0;

            if (w_timeout)    r_timeout_err <= 1'b1;
            else if (clr_err) r_timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_mpu_seq.sv
// tb/tb_spi_mpu_seq.sv - self-checking bench for spi_mpu_seq with an engine model and scoreboard
module tb_spi_mpu_seq;

    localparam int NREG = 3;
    localparam int FW   = NREG * 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          trigger = 1'b0;
    logic          clr_err = 1'b0;
    logic          spi_busy = 1'b0;
    logic          spi_finish = 1'b0;
    logic [7:0]    spi_data = 8'h00;
    logic          spi_start;
    logic [7:0]    spi_addr;
    logic [FW-1:0] frame;
    logic          frame_valid;
    logic          seq_busy;
    logic          overrun;
    logic          timeout_err;

    spi_mpu_seq #(
        .NREG      (NREG),
        .BASE_ADDR (7'h3B),
        .RATE_DIV  (100),
        .TIMEOUT   (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .trigger     (trigger),
        .clr_err     (clr_err),
        .spi_busy    (spi_busy),
        .spi_finish  (spi_finish),
        .spi_data    (spi_data),
        .spi_start   (spi_start),
        .spi_addr    (spi_addr),
        .frame       (frame),
        .frame_valid (frame_valid),
        .seq_busy    (seq_busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [7:0]    exp_addr_q[$];
    logic [FW-1:0] exp_frame_q[$];
    logic [7:0]    eng_tab [0:127];
    bit            eng_active = 1'b0;
    bit            eng_dead = 1'b0;
    bit            busy_force = 1'b0;
    int            eng_lat = 1;
    int            eng_cnt = 0;
    logic [6:0]    eng_addr = 7'h00;
    int            n_start = 0;
    int            first_start_cyc = 0;
    int            n_fv = 0;
    int            fv_cyc_q[$];
    logic [FW-1:0] last_frame = '0;

    // engine model and scoreboard, one call per clock
    task automatic advance();
        logic [7:0]    ea;
        logic [FW-1:0] ef;
        @(posedge clk);
        #1;
        cyc++;
        spi_finish = 1'b0;
        if (eng_active) begin
            if (eng_cnt == 0) begin
                spi_finish = 1'b1;
                spi_data   = eng_tab[eng_addr];
                eng_active = 1'b0;
            end else begin
                eng_cnt--;
            end
        end
        spi_busy = eng_active | busy_force;
        #1;
        if (spi_start) begin
            total++;
            if (exp_addr_q.size() == 0) begin
                bad++;
                $display("FAIL start_unexpected: addr=%02h cycle=%0d, none expected", spi_addr, cyc);
            end else begin
                ea = exp_addr_q.pop_front();
                if (spi_addr !== ea) begin
                    bad++;
                    $display("FAIL spi_addr: got %02h want %02h cycle=%0d", spi_addr, ea, cyc);
                end
            end
            if (n_start == 0) first_start_cyc = cyc;
            n_start++;
            if (!eng_dead) begin
                eng_active = 1'b1;
                eng_cnt    = eng_lat;
                eng_addr   = spi_addr[6:0];
            end
        end
        if (frame_valid) begin
            total++;
            if (exp_frame_q.size() == 0) begin
                bad++;
                $display("FAIL frame_valid_unexpected: frame=%06h cycle=%0d", frame, cyc);
            end else begin
                ef = exp_frame_q.pop_front();
                last_frame = ef;
                if (frame !== ef) begin
                    bad++;
                    $display("FAIL frame: got %06h want %06h cycle=%0d", frame, ef, cyc);
                end
            end
            n_fv++;
            fv_cyc_q.push_back(cyc);
        end
    endtask

    task automatic expect_frame(input logic [FW-1:0] f);
        exp_addr_q.push_back(8'hBB);
        exp_addr_q.push_back(8'hBC);
        exp_addr_q.push_back(8'hBD);
        exp_frame_q.push_back(f);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || exp_frame_q.size() != 0 || seq_busy) && n < max_cyc) begin
            advance();
            n++;
        end
        total++;
        if (n >= max_cyc) begin
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, addr_q=%0d frame_q=%0d",
                     n, exp_addr_q.size(), exp_frame_q.size());
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        advance();
        trigger = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({spi_start, spi_addr, frame, frame_valid, seq_busy, overrun, timeout_err} !== '0) begin
            bad++;
            $display("FAIL %s: start=%0b addr=%02h frame=%06h fv=%0b busy=%0b ovr=%0b to=%0b, want all 0",
                     tag, spi_start, spi_addr, frame, frame_valid, seq_busy, overrun, timeout_err);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset_state");
        rst = 1'b0;
        repeat (3) advance();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_manual();
        int trig_cyc;
        eng_tab[7'h3B] = 8'hA1; eng_tab[7'h3C] = 8'hB2; eng_tab[7'h3D] = 8'hC3;
        eng_lat = 2; n_start = 0; n_fv = 0;
        expect_frame(24'hC3B2A1);
        trig_cyc = cyc;
        pulse_trigger();
        wait_idle(100);
        total++;
        if (first_start_cyc - trig_cyc !== 2) begin
            bad++; $display("FAIL manual_latency: got %0d want 2", first_start_cyc - trig_cyc);
        end
        total++;
        if (n_start !== 3) begin bad++; $display("FAIL manual_starts: got %0d want 3", n_start); end
        repeat (5) advance();
        total++;
        if (n_fv !== 1) begin bad++; $display("FAIL manual_fv_count: got %0d want 1", n_fv); end
        total++;
        if (frame !== 24'hC3B2A1) begin bad++; $display("FAIL manual_frame_hold: got %06h want c3b2a1", frame); end
    endtask

    task automatic test_periodic();
        eng_tab[7'h3B] = 8'h11; eng_tab[7'h3C] = 8'h22; eng_tab[7'h3D] = 8'h33;
        eng_lat = 1; n_fv = 0; fv_cyc_q.delete();
        for (int i = 0; i < 10; i++) expect_frame(24'h332211);
        enable = 1'b1;
        repeat (1000) advance();
        enable = 1'b0;
        repeat (60) advance();
        total++;
        if (n_fv !== 10) begin bad++; $display("FAIL periodic_count: got %0d want 10", n_fv); end
        for (int i = 1; i < fv_cyc_q.size(); i++) begin
            total++;
            if (fv_cyc_q[i] - fv_cyc_q[i-1] !== 100) begin
                bad++; $display("FAIL periodic_spacing[%0d]: got %0d want 100", i, fv_cyc_q[i] - fv_cyc_q[i-1]);
            end
        end
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL periodic_overrun: got %0b want 0", overrun); end
        total++;
        if (exp_frame_q.size() !== 0) begin
            bad++; $display("FAIL periodic_leftover: got %0d frames pending want 0", exp_frame_q.size());
        end
    endtask

    task automatic test_overrun();
        int n;
        eng_tab[7'h3B] = 8'h5A; eng_tab[7'h3C] = 8'h6B; eng_tab[7'h3D] = 8'h7C;
        eng_lat = 3; n_start = 0; n_fv = 0;
        expect_frame(24'h7C6B5A);
        pulse_trigger();
        n = 0;
        while (n_start == 0 && n < 10) begin advance(); n++; end
        pulse_trigger();
        advance();
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %0b want 1", overrun); end
        wait_idle(100);
        repeat (20) advance();
        total++;
        if (n_start !== 3) begin bad++; $display("FAIL overrun_starts: got %0d want 3", n_start); end
        total++;
        if (n_fv !== 1) begin bad++; $display("FAIL overrun_fv_count: got %0d want 1", n_fv); end
        clr_err = 1'b1;
        advance();
        clr_err = 1'b0;
        advance();
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %0b want 0", overrun); end
    endtask

    task automatic test_timeout();
        int n;
        int err_cyc;
        logic [FW-1:0] held;
        held = last_frame;
        eng_dead = 1'b1; n_start = 0; n_fv = 0;
        exp_addr_q.push_back(8'hBB);
        pulse_trigger();
        n = 0;
        while (n_start == 0 && n < 10) begin advance(); n++; end
        n = 0;
        err_cyc = -1;
        while (err_cyc < 0 && n < 60) begin
            advance();
            n++;
            if (timeout_err === 1'b1) err_cyc = cyc;
        end
        total++;
        if (err_cyc - first_start_cyc !== 21) begin
            bad++; $display("FAIL timeout_latency: got %0d want 21", err_cyc - first_start_cyc);
        end
        total++;
        if (seq_busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: seq_busy=%0b want 0", seq_busy); end
        repeat (5) advance();
        total++;
        if (frame !== held) begin bad++; $display("FAIL timeout_frame: got %06h want %06h", frame, held); end
        total++;
        if (n_fv !== 0) begin bad++; $display("FAIL timeout_fv: got %0d want 0", n_fv); end
        eng_dead = 1'b0;
        clr_err = 1'b1;
        advance();
        clr_err = 1'b0;
        advance();
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %0b want 0", timeout_err); end
    endtask

    task automatic test_reset_mid();
        int n;
        eng_tab[7'h3B] = 8'hA1; eng_tab[7'h3C] = 8'hB2; eng_tab[7'h3D] = 8'hC3;
        eng_lat = 2; n_start = 0; n_fv = 0;
        expect_frame(24'hC3B2A1);
        pulse_trigger();
        n = 0;
        while (n_start < 2 && n < 30) begin advance(); n++; end
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_frame");
        exp_addr_q.delete();
        exp_frame_q.delete();
        eng_active = 1'b0;
        spi_finish = 1'b0;
        spi_busy   = 1'b0;
        last_frame = '0;
        advance();
        advance();
        rst = 1'b0;
        advance();
        n_start = 0; n_fv = 0;
        expect_frame(24'hC3B2A1);
        pulse_trigger();
        wait_idle(100);
        total++;
        if (n_fv !== 1 || frame !== 24'hC3B2A1) begin
            bad++; $display("FAIL reset_refetch: fv=%0d frame=%06h want 1 c3b2a1", n_fv, frame);
        end
    endtask

    task automatic test_busy_engine();
        int trig_cyc;
        n_start = 0; n_fv = 0;
        busy_force = 1'b1;
        expect_frame(24'hC3B2A1);
        trig_cyc = cyc;
        pulse_trigger();
        repeat (5) advance();
        total++;
        if (n_start !== 0) begin bad++; $display("FAIL busy_withheld: got %0d starts want 0", n_start); end
        busy_force = 1'b0;
        wait_idle(100);
        total++;
        if (first_start_cyc - trig_cyc !== 7) begin
            bad++; $display("FAIL busy_release: start at +%0d want +7", first_start_cyc - trig_cyc);
        end
        total++;
        if (n_start !== 3 || n_fv !== 1) begin
            bad++; $display("FAIL busy_frame: starts=%0d fv=%0d want 3 1", n_start, n_fv);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_periodic();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_busy_engine();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
